// File: rtl/layer_output_collector.sv
// Collects NEURONS activated float32 results into one packed vector for the next layer,
// with valid/ready handshakes on both sides and a registered full-vector output buffer.
module layer_output_collector #(
    parameter int unsigned NEURONS = 4,
    parameter int unsigned ACT     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic [31:0]                  in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [32*NEURONS-1:0]        out_vec,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NEURONS+1)-1:0] count
);

    localparam int unsigned CW = $clog2(NEURONS + 1);

    typedef enum logic [0:0] {StCollect, StFull} state_t;

    state_t      state;
    logic [31:0] act_data;
    logic        in_fire;

    // ReLU: negatives (incl. -0/-Inf) flush to +0, NaNs canonicalise, rest pass through.
    always_comb begin
        act_data = in_data;
        if (ACT == 1) begin
            if (in_data[30:23] == 8'hFF && in_data[22:0] != 23'd0) begin
                act_data = 32'h7FC0_0000;
            end else if (in_data[31]) begin
                act_data = 32'h0000_0000;
            end
        end
    end

    assign in_ready = (state == StCollect);
    assign in_fire  = in_valid && in_ready && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StCollect;
            count     <= '0;
            out_vec   <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                StCollect: begin
                    if (clear) begin
                        count <= '0;
                    end else if (in_fire) begin
                        for (int i = 0; i < int'(NEURONS); i++) begin
                            if (count == CW'(i)) begin
                                out_vec[32*i +: 32] <= act_data;
                            end
                        end
                        if (count == CW'(NEURONS - 1)) begin
                            state     <= StFull;
                            count     <= CW'(NEURONS);
                            out_valid <= 1'b1;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                StFull: begin
                    // clear is deliberately ignored here: a completed vector is never dropped.
                    if (out_ready) begin
                        state     <= StCollect;
                        count     <= '0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= StCollect;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_output_collector.sv
// Directed bench for layer_output_collector: a NEURONS=4/ReLU instance and a NEURONS=1/identity one.
module tb_layer_output_collector;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         clear0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [31:0]  in_data0;
    logic [127:0] out_vec0;
    logic [2:0]   count0;

    logic         clear1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0]  in_data1;
    logic [31:0]  out_vec1;
    logic [0:0]   count1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] held_vec;

    always #5 clk = ~clk;

    layer_output_collector #(.NEURONS(4), .ACT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear0), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .out_vec(out_vec0), .out_valid(out_valid0),
        .out_ready(out_ready0), .count(count0)
    );

    layer_output_collector #(.NEURONS(1), .ACT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear1), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .out_vec(out_vec1), .out_valid(out_valid1),
        .out_ready(out_ready1), .count(count1)
    );

    // Present one beat to dut0 at the falling edge; it is taken on the next rising edge.
    task automatic send0(input logic [31:0] d);
        @(negedge clk);
        in_valid0 = 1'b1;
        in_data0  = d;
    endtask

    task automatic idle0;
        @(negedge clk);
        in_valid0 = 1'b0;
        in_data0  = 32'h0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear0 = 0; in_valid0 = 0; in_data0 = 0; out_ready0 = 1;
        clear1 = 0; in_valid1 = 0; in_data1 = 0; out_ready1 = 1;
        #1;
        n_checks++;
        if (count0 !== 3'd0) $display("FAIL reset_count: got %0d want 0", count0); else n_pass++;
        n_checks++;
        if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid0);
        else n_pass++;
        n_checks++;
        if (in_ready0 !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready0);
        else n_pass++;
        n_checks++;
        if (out_vec0 !== 128'h0) $display("FAIL reset_out_vec: got %h want 0", out_vec0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream;
        out_ready0 = 1'b1;
        send0(32'h3F80_0000);
        send0(32'hBF80_0000);
        send0(32'h4000_0000);
        send0(32'h8000_0000);
        idle0();
        n_checks++;
        if (out_valid0 !== 1'b1) $display("FAIL stream_valid: got %b want 1", out_valid0);
        else n_pass++;
        n_checks++;
        if (out_vec0 !== {32'h0, 32'h4000_0000, 32'h0, 32'h3F80_0000})
            $display("FAIL stream_vec: got %h want %h", out_vec0,
                     {32'h0, 32'h4000_0000, 32'h0, 32'h3F80_0000});
        else n_pass++;
        n_checks++;
        if (in_ready0 !== 1'b0 || count0 !== 3'd4)
            $display("FAIL stream_full: got ready=%b count=%0d want 0/4", in_ready0, count0);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || count0 !== 3'd0)
            $display("FAIL stream_drain: got valid=%b ready=%b count=%0d want 0/1/0",
                     out_valid0, in_ready0, count0);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        out_ready0 = 1'b0;
        send0(32'h3F80_0000);
        send0(32'h4000_0000);
        send0(32'h4040_0000);
        send0(32'h4080_0000);
        held_vec = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid0 = 1'b1;
            in_data0  = 32'h4120_0000;
            n_checks++;
            if (in_ready0 !== 1'b0 || count0 !== 3'd4 || out_valid0 !== 1'b1 ||
                out_vec0 !== held_vec)
                $display("FAIL bp_hold[%0d]: got ready=%b count=%0d valid=%b vec=%h want 0/4/1/%h",
                         i, in_ready0, count0, out_valid0, out_vec0, held_vec);
            else n_pass++;
        end
        @(negedge clk);
        in_valid0  = 1'b0;
        out_ready0 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (count0 !== 3'd0 || out_valid0 !== 1'b0 || out_vec0 !== held_vec)
            $display("FAIL bp_release: got count=%0d valid=%b vec=%h want 0/0/%h",
                     count0, out_valid0, out_vec0, held_vec);
        else n_pass++;
    endtask

    task automatic test_special;
        out_ready0 = 1'b1;
        send0(32'h7FC1_2345);
        send0(32'hFF80_0000);
        send0(32'h7F80_0000);
        send0(32'h0000_0001);
        idle0();
        n_checks++;
        if (out_valid0 !== 1'b1 ||
            out_vec0 !== {32'h0000_0001, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000})
            $display("FAIL special_vec: got valid=%b vec=%h want 1/%h", out_valid0, out_vec0,
                     {32'h0000_0001, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000});
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_clear;
        out_ready0 = 1'b1;
        send0(32'h3F80_0000);
        send0(32'h4000_0000);
        @(negedge clk);
        clear0    = 1'b1;
        in_valid0 = 1'b1;
        in_data0  = 32'h4200_0000;
        @(negedge clk);
        clear0    = 1'b0;
        in_valid0 = 1'b0;
        n_checks++;
        if (count0 !== 3'd0) $display("FAIL clear_count: got %0d want 0", count0); else n_pass++;
        send0(32'h40A0_0000);
        send0(32'h40C0_0000);
        send0(32'h40E0_0000);
        n_checks++;
        if (out_valid0 !== 1'b0) $display("FAIL clear_early_valid: got %b want 0", out_valid0);
        else n_pass++;
        send0(32'h4100_0000);
        idle0();
        n_checks++;
        if (out_valid0 !== 1'b1 ||
            out_vec0 !== {32'h4100_0000, 32'h40E0_0000, 32'h40C0_0000, 32'h40A0_0000})
            $display("FAIL clear_vec: got valid=%b vec=%h want 1/%h", out_valid0, out_vec0,
                     {32'h4100_0000, 32'h40E0_0000, 32'h40C0_0000, 32'h40A0_0000});
        else n_pass++;
        @(negedge clk);

        // clear while FULL must not discard the vector
        out_ready0 = 1'b0;
        send0(32'h4110_0000);
        send0(32'h4120_0000);
        send0(32'h4130_0000);
        send0(32'h4140_0000);
        idle0();
        clear0   = 1'b1;
        held_vec = {32'h4140_0000, 32'h4130_0000, 32'h4120_0000, 32'h4110_0000};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid0 !== 1'b1 || count0 !== 3'd4 || out_vec0 !== held_vec)
                $display("FAIL clear_full[%0d]: got valid=%b count=%0d vec=%h want 1/4/%h",
                         i, out_valid0, count0, out_vec0, held_vec);
            else n_pass++;
        end
        clear0     = 1'b0;
        out_ready0 = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        out_ready0 = 1'b1;
        send0(32'h3F80_0000);
        send0(32'h4000_0000);
        send0(32'h4040_0000);
        idle0();
        n_checks++;
        if (count0 !== 3'd3) $display("FAIL mid_pre_count: got %0d want 3", count0); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (count0 !== 3'd0 || out_valid0 !== 1'b0 || out_vec0 !== 128'h0 || in_ready0 !== 1'b1)
            $display("FAIL mid_reset: got count=%0d valid=%b vec=%h ready=%b want 0/0/0/1",
                     count0, out_valid0, out_vec0, in_ready0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        send0(32'h3F80_0000);
        send0(32'h3F80_0000);
        send0(32'h3F80_0000);
        idle0();
        n_checks++;
        if (out_valid0 !== 1'b0 || count0 !== 3'd3)
            $display("FAIL mid_refill: got valid=%b count=%0d want 0/3", out_valid0, count0);
        else n_pass++;
        send0(32'h4000_0000);
        idle0();
        n_checks++;
        if (out_valid0 !== 1'b1 ||
            out_vec0 !== {32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000})
            $display("FAIL mid_vec: got valid=%b vec=%h want 1/%h", out_valid0, out_vec0,
                     {32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000});
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_single;
        out_ready1 = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0)
            $display("FAIL single_idle: got ready=%b valid=%b want 1/0", in_ready1, out_valid1);
        else n_pass++;
        in_valid1 = 1'b1;
        in_data1  = 32'hC049_0FDB;
        @(negedge clk);
        in_valid1 = 1'b0;
        n_checks++;
        if (out_valid1 !== 1'b1 || out_vec1 !== 32'hC049_0FDB || count1 !== 1'b1)
            $display("FAIL single_vec: got valid=%b vec=%h count=%0d want 1/c0490fdb/1",
                     out_valid1, out_vec1, count1);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1)
            $display("FAIL single_drain: got valid=%b ready=%b want 0/1", out_valid1, in_ready1);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_special();
        test_clear();
        test_reset_mid();
        test_single();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer_output_collector.md
# layer_output_collector

Collects the scalar float32 results of successive dot-product stages (one per neuron) and applies the activation function to each. Packs them into a single `32*NEURONS` vector for the next layer's vector-multiplication input. Sits directly downstream of the vector multiplier / dot-product stage and directly upstream of the next layer's dot-product stage. Uses a valid/ready handshake on both sides and a full-vector output buffer.

## Interface
- `NEURONS`, 4: number of scalar results per output vector; must be ≥ 1.
- `ACT`, 1: activation function; 0 = identity, 1 = ReLU.
- `clk`  input  1  the block's single clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `clear`  input  1  synchronous; discards a partially collected vector.
- `in_data`  input  32  IEEE-754 single-precision neuron result.
- `in_valid`  input  1  `in_data` is valid this cycle.
- `in_ready`  output  1  the block accepts `in_data` this cycle.
- `out_vec`  output  32*NEURONS  packed vector; element i at `[32*i +: 32]`.
- `out_valid`  output  1  `out_vec` is complete and stable.
- `out_ready`  input  1  the consumer takes `out_vec` this cycle.
- `count`  output  $clog2(NEURONS+1)  number of elements currently stored.

## Operation
- Two states:
  - COLLECT: `out_valid`=0, `in_ready`=1.
  - FULL: `out_valid`=1, `in_ready`=0.
- Input transfer occurs when `in_valid && in_ready`:
  - The activated value is written to slot `count`.
  - `count` increments.
- When the transfer that fills slot NEURONS-1 occurs, the block goes to FULL and `count` becomes NEURONS.
- Output transfer occurs in FULL when `out_ready`=1:
  - The block goes to COLLECT and `count` returns to 0.
  - `out_vec` retains its last value; slots are overwritten by later inputs.
- Input and output transfers never coincide, because `in_ready` is 0 in FULL.
- Activation applies to the stored value only; it adds no extra cycle.
- With ACT=0, bits are stored unchanged.
- With ACT=1:
  - Sign=1 and not NaN (including -0 and -Inf): store 0x00000000.
  - NaN (exponent 0xFF, mantissa ≠ 0): store canonical 0x7FC00000.
  - All other values: store unchanged. +Inf and denormals pass through.
- `clear`=1:
  - In COLLECT, `count` goes to 0 on the next edge, and any input transfer in the same cycle is dropped.
  - In FULL, `clear` is ignored; a completed vector is never discarded.
- `in_data` is sampled only on a transfer. Values presented while `in_ready`=0 are ignored.

## Timing
- Reset (`rst_n`=0, asynchronous) forces:
  - COLLECT state.
  - `count`=0, `out_valid`=0, `in_ready`=1, `out_vec`=all zeros.
- After reset is released, the first input transfer can occur on the first rising edge.
- Latency: `out_valid` rises on the same edge that captures the NEURONS-th input, and is visible in the cycle after that transfer.
- `out_vec` and `out_valid` are registered. While `out_valid`=1 and `out_ready`=0, they are held stable indefinitely.
- `in_ready` is a combinational decode of state only, with no path from `in_valid` or `out_ready`.
- Throughput: NEURONS cycles per vector plus 1 cycle in FULL (minimum), i.e. one vector per NEURONS+1 cycles.
- NEURONS=1: every input transfer moves the block directly to FULL.
- Reset asserted mid-collection or during FULL: all collected data is lost and the block returns to the reset values above.

## Test plan
- NEURONS=4, ACT=1, with `out_ready`=1:
  - Stimulus: stream 0x3F800000, 0xBF800000, 0x40000000, 0x80000000 on consecutive cycles.
  - Required response: `out_valid`=1 the next cycle with `out_vec`={0x00000000, 0x40000000, 0x00000000, 0x3F800000} (element 3 down to element 0).
  - Then `out_valid`=0 and `in_ready`=1 on the following cycle.
- Backpressure:
  - Stimulus: fill the buffer, hold `out_ready`=0 for 5 cycles while driving `in_valid`=1 with 0x41200000.
  - Required response: `in_ready`=0, `count`=4 and `out_vec` unchanged throughout; none of the 0x41200000 values are stored.
- ACT=1 special values:
  - Stimulus: inputs 0x7FC12345 (NaN), 0xFF800000 (-Inf), 0x7F800000 (+Inf), 0x00000001 (denormal).
  - Required response: stored as 0x7FC00000, 0x00000000, 0x7F800000, 0x00000001.
- `clear`:
  - Stimulus: after 2 inputs, assert `clear` with `in_valid`=1.
  - Required response: `count`=0 next cycle and the input is dropped; 4 further inputs produce a vector containing only those 4.
  - Stimulus: assert `clear` in FULL.
  - Required response: no effect.
- Reset mid-operation:
  - Stimulus: drive `rst_n`=0 asynchronously (between clock edges) with `count`=3; then release reset.
  - Required response: immediately `count`=0, `out_valid`=0, `out_vec`=0, `in_ready`=1.
  - After release: a full new vector is required before `out_valid` rises.
- NEURONS=1, ACT=0:
  - Stimulus: input 0xC0490FDB.
  - Required response: `out_valid`=1 next cycle with `out_vec`=0xC0490FDB.
